wb_initiator: RTL and testbench

//  Wishbone classic single-cycle bus initiator for the user-project clock domain.

---
 rtl/wb_initiator_pkg.sv | 22 ++
 rtl/wb_initiator.sv | 120 ++++++++++++
 tb/tb_wb_initiator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types for the Wishbone classic initiator: FSM states, the latched
// request bundle and the default bus widths.
package wb_initiator_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int SELW  = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [SELW-1:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one request at a time is turned into a single
// cyc/stb cycle, and the result (read data or timeout error) is returned as a response.
import wb_initiator_pkg::*;

module wb_initiator #(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  // A zero TIMEOUT disables the abort; the counter then never moves.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t        state_q;
  wb_req_t       req_q;
  logic          cyc_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          expire_d;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = req_q.we;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbm_sel_o = req_q.sel;

  // Timeout step: expire on the last allowed BUS cycle, otherwise count up (never wraps).
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (TIMEOUT == 0) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_LAST) begin
      expire_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Transaction FSM with all handshake and bus outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cyc_q     <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q     <= '{we: req_we, adr: req_adr, dat: req_dat, sel: req_sel};
            cnt_q     <= '0;
            cyc_q     <= 1'b1;
            req_ready <= 1'b0;
            state_q   <= BUS;
          end
        end
        BUS: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (wbm_ack_i) begin
            rsp_dat   <= req_q.we ? '0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            cyc_q     <= 1'b0;
            state_q   <= RESP;
          end else if (expire_d) begin
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            cyc_q     <= 1'b0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          cyc_q     <= 1'b0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator (TIMEOUT=4): directed cases followed by
// randomized transactions compared against a transaction-level expectation.
module tb_wb_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o, ack;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;

  int checks = 0;
  int errors = 0;

  wb_initiator #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr  (req_adr),   .req_dat  (req_dat),   .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc),       .wbm_stb_o(stb),       .wbm_we_o(we_o),
    .wbm_adr_o(adr_o),     .wbm_dat_o(dat_o),     .wbm_sel_o(sel_o),
    .wbm_ack_i(ack),       .wbm_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: ack_at in 1..TO acks on that BUS cycle; anything else never acks in time.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int ack_at, input logic [31:0] rdata,
                     input int rsp_wait);
    int          c;
    int          exp_cycles;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_cycles = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    exp_err    = !(ack_at >= 1 && ack_at <= TO);
    exp_dat    = (!exp_err && !w) ? rdata : 32'h0;

    check("req_ready_idle", {127'd0, req_ready}, 128'd1);
    req_valid = 1'b1; req_we = w; req_adr = a; req_dat = d; req_sel = s;
    step();
    req_valid = $urandom_range(0, 1); req_we = ~w; req_adr = $urandom; req_dat = $urandom;
    req_sel = 4'($urandom);

    c = 1;
    while (c < 20) begin
      check("bus_hold", {57'd0, cyc, stb, we_o, adr_o, dat_o, sel_o, req_ready},
            {57'd0, 1'b1, 1'b1, w, a, d, s, 1'b0});
      ack   = (c == ack_at);
      dat_i = (c == ack_at) ? rdata : $urandom;
      step();
      if (!cyc) break;
      c++;
    end
    check("bus_cycles", 128'(c), 128'(exp_cycles));

    for (int i = 0; i <= rsp_wait; i++) begin
      check("rsp_hold", {93'd0, rsp_valid, rsp_err, rsp_dat, req_ready, cyc},
            {93'd0, 1'b1, exp_err, exp_dat, 1'b0, 1'b0});
      ack       = $urandom_range(0, 1);
      dat_i     = $urandom;
      req_valid = 1'b1;
      rsp_ready = (i == rsp_wait);
      if (i == rsp_wait) req_valid = 1'b0;
      step();
    end
    rsp_ready = 1'b0;
    ack       = 1'b0;
    check("rsp_done", {125'd0, rsp_valid, req_ready, cyc}, {125'd0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    step(); step();
    check("reset_outs", {rsp_dat, adr_o, dat_o, 22'd0, sel_o, req_ready, rsp_valid, rsp_err, cyc, stb, we_o},
          {32'h0, 32'h0, 32'h0, 22'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    step();

    txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678, 5);
    txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'h5555_5555, 1);
    txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 4, 32'hA5A5_A5A5, 0);
    txn(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'h1, 0, 32'h0, 2);

    // Reset pulsed in the second BUS cycle, then a late ack that must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020; req_sel = 4'hF;
    step();
    req_valid = 1'b0; ack = 1'b0;
    step();
    check("pre_rst_cyc", {127'd0, cyc}, 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid", {93'd0, cyc, stb, rsp_valid, req_ready, rsp_dat},
          {93'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    ack = 1'b1; dat_i = 32'hCAFE_0001;
    step();
    ack = 1'b0;
    check("late_ack", {124'd0, cyc, rsp_valid, req_ready, rsp_err}, {124'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    step();

    for (int n = 0; n < 30; n++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
          $urandom_range(0, TO + 1), $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
